// File: rtl/bp_pkg.sv
// Shared types and sizing helpers for the branch predictor.
package bp_pkg;

  // 2-bit saturating direction counter encoding
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_state_e;

  // Tag width: PC bits above the index field and the word offset
  function automatic int unsigned tag_width(input int unsigned data_width,
                                            input int unsigned index_bits);
    return data_width - index_bits - 32'd2;
  endfunction

  // Number of table entries
  function automatic int unsigned num_entries(input int unsigned index_bits);
    return 32'd1 << index_bits;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2 import bp_pkg::*; (
  input  logic [1:0] i_state,
  input  logic       i_taken,
  output logic [1:0] o_next_state
);

  // Step toward taken / not-taken, holding at the ends
  always_comb begin
    o_next_state = i_state;
    if (i_taken) begin
      if (i_state != STRONG_T) o_next_state = i_state + 2'd1;
    end else begin
      if (i_state != STRONG_NT) o_next_state = i_state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters,
// misprediction detection and resolved / mispredicted branch counters.
module branch_predictor import bp_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fetchPC,
  output logic                  predictTaken,
  output logic [DATA_WIDTH-1:0] predictTarget,
  input  logic                  updateEn,
  input  logic [DATA_WIDTH-1:0] updatePC,
  input  logic [DATA_WIDTH-1:0] updateTarget,
  input  logic                  actualTaken,
  input  logic                  exPredictTaken,
  input  logic [DATA_WIDTH-1:0] exPredictTarget,
  output logic                  mispredict,
  output logic [31:0]           branchCount,
  output logic [31:0]           mispredictCount
);

  localparam int TAG_W       = int'(tag_width(DATA_WIDTH, INDEX_BITS));
  localparam int NUM_ENTRIES = int'(num_entries(INDEX_BITS));

  logic                  r_valid  [NUM_ENTRIES];
  logic [TAG_W-1:0]      r_tag    [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [NUM_ENTRIES];
  logic [1:0]            r_ctr    [NUM_ENTRIES];
  logic [31:0]           r_branch_count;
  logic [31:0]           r_mispredict_count;

  logic [INDEX_BITS-1:0] w_fidx;
  logic [TAG_W-1:0]      w_ftag;
  logic                  w_fhit;
  logic [INDEX_BITS-1:0] w_uidx;
  logic [TAG_W-1:0]      w_utag;
  logic                  w_uhit;
  logic [1:0]            w_ctr_next;
  logic                  w_unused_pc_bits;

  // Word offset bits never select an entry
  assign w_unused_pc_bits = ^{fetchPC[1:0], updatePC[1:0]};

  assign w_fidx = fetchPC[INDEX_BITS+1:2];
  assign w_ftag = fetchPC[DATA_WIDTH-1:INDEX_BITS+2];
  assign w_uidx = updatePC[INDEX_BITS+1:2];
  assign w_utag = updatePC[DATA_WIDTH-1:INDEX_BITS+2];

  // Lookup reads registered state only, so same-cycle updates are not bypassed
  assign w_fhit        = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign predictTaken  = w_fhit && r_ctr[w_fidx][1];
  assign predictTarget = predictTaken ? r_target[w_fidx] : '0;

  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  // Wrong direction, or taken with a wrong target
  assign mispredict = updateEn &&
                      ((actualTaken != exPredictTaken) ||
                       (actualTaken && (exPredictTarget != updateTarget)));

  sat_counter2 u_sat_counter2 (
    .i_state      (r_ctr[w_uidx]),
    .i_taken      (actualTaken),
    .o_next_state (w_ctr_next)
  );

  // Table update: train on hit, allocate only on a taken miss
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= WEAK_NT;
      end
    end else if (updateEn) begin
      if (w_uhit) begin
        r_ctr[w_uidx] <= w_ctr_next;
        if (actualTaken) r_target[w_uidx] <= updateTarget;
      end else if (actualTaken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= updateTarget;
        r_ctr[w_uidx]    <= WEAK_T;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (updateEn && (r_branch_count != 32'hFFFF_FFFF)) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign branchCount     = r_branch_count;
  assign mispredictCount = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expected observations are queued as
// stimulus is applied and compared when the DUT outputs are sampled mid-cycle.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetchPC = '0;
  logic        predictTaken;
  logic [31:0] predictTarget;
  logic        updateEn = 1'b0;
  logic [31:0] updatePC = '0;
  logic [31:0] updateTarget = '0;
  logic        actualTaken = 1'b0;
  logic        exPredictTaken = 1'b0;
  logic [31:0] exPredictTarget = '0;
  logic        mispredict;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  always #5 clk = ~clk;

  branch_predictor #(
    .DATA_WIDTH (32),
    .INDEX_BITS (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetchPC         (fetchPC),
    .predictTaken    (predictTaken),
    .predictTarget   (predictTarget),
    .updateEn        (updateEn),
    .updatePC        (updatePC),
    .updateTarget    (updateTarget),
    .actualTaken     (actualTaken),
    .exPredictTaken  (exPredictTaken),
    .exPredictTarget (exPredictTarget),
    .mispredict      (mispredict),
    .branchCount     (branchCount),
    .mispredictCount (mispredictCount)
  );

  typedef struct packed {
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] bc;
    logic [31:0] mc;
  } obs_t;

  typedef struct {
    logic        en;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        act;
    logic        expt;
    logic [31:0] extgt;
    logic [31:0] fpc;
    logic        ept;
    logic [31:0] etgt;
    logic        emp;
  } row_t;

  obs_t        sb_q [$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_bc = '0;
  logic [31:0] exp_mc = '0;

  // Apply one cycle of stimulus just after a rising edge and queue what the
  // outputs must show before the next edge; counts advance at that edge.
  task automatic drive(input row_t r);
    @(posedge clk);
    #1;
    updateEn        = r.en;
    updatePC        = r.upc;
    updateTarget    = r.utgt;
    actualTaken     = r.act;
    exPredictTaken  = r.expt;
    exPredictTarget = r.extgt;
    fetchPC         = r.fpc;
    sb_q.push_back({r.ept, r.etgt, r.emp, exp_bc, exp_mc});
    if (r.en) begin
      if (exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 32'd1;
      if (r.emp && exp_mc != 32'hFFFF_FFFF) exp_mc = exp_mc + 32'd1;
    end
  endtask

  task automatic test_reset();
    obs_t e;
    obs_t got;
    // In reset with a live mispredicting update on the inputs
    updateEn = 1'b1; updatePC = 32'h100; updateTarget = 32'h200;
    actualTaken = 1'b1; exPredictTaken = 1'b0; exPredictTarget = '0;
    fetchPC = 32'h100;
    sb_q.push_back({1'b0, 32'h0, 1'b1, 32'h0, 32'h0});
    #3;
    e = sb_q.pop_front();
    got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
    checks++;
    if (got !== e) begin
      failures++; $display("FAIL reset_lookup: got=%h required=%h", got, e);
    end
    // An edge while still in reset must discard the update
    @(posedge clk);
    #1;
    sb_q.push_back({1'b0, 32'h0, 1'b1, 32'h0, 32'h0});
    e = sb_q.pop_front();
    got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
    checks++;
    if (got !== e) begin
      failures++; $display("FAIL reset_discard: got=%h required=%h", got, e);
    end
    updateEn = 1'b0;
    sb_q.push_back({1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    #1;
    e = sb_q.pop_front();
    got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
    checks++;
    if (got !== e) begin
      failures++; $display("FAIL reset_idle: got=%h required=%h", got, e);
    end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_alloc();
    row_t rows [2];
    obs_t e;
    obs_t got;
    rows = '{
      '{1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0, 32'h100, 1'b0, 32'h0,   1'b1},
      '{1'b0, 32'h140, 32'h999, 1'b1, 1'b0, 32'h0, 32'h100, 1'b1, 32'h200, 1'b0}
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      e = sb_q.pop_front();
      got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL alloc[%0d]: got=%h required=%h", i, got, e);
      end
    end
  endtask

  task automatic test_counter();
    row_t rows [7];
    obs_t e;
    obs_t got;
    rows = '{
      '{1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200, 1'b0},
      '{1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200, 1'b0},
      '{1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200, 1'b0},
      '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h100, 1'b1, 32'h200, 1'b0},
      '{1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200, 1'b1},
      '{1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200, 1'b1},
      '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h100, 1'b0, 32'h0,   1'b0}
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      e = sb_q.pop_front();
      got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL counter[%0d]: got=%h required=%h", i, got, e);
      end
    end
  endtask

  task automatic test_no_alloc();
    row_t rows [2];
    obs_t e;
    obs_t got;
    rows = '{
      '{1'b1, 32'h184, 32'h400, 1'b0, 1'b0, 32'h0, 32'h184, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h184, 32'h400, 1'b1, 1'b0, 32'h0, 32'h184, 1'b0, 32'h0, 1'b0}
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      e = sb_q.pop_front();
      got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL no_alloc[%0d]: got=%h required=%h", i, got, e);
      end
    end
  endtask

  task automatic test_alias();
    row_t rows [6];
    obs_t e;
    obs_t got;
    rows = '{
      '{1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h204, 32'h100, 1'b0, 32'h0,   1'b1},
      '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h100, 1'b1, 32'h200, 1'b0},
      '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h140, 1'b0, 32'h0,   1'b0},
      '{1'b1, 32'h140, 32'h300, 1'b1, 1'b0, 32'h0,   32'h140, 1'b0, 32'h0,   1'b1},
      '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h140, 1'b1, 32'h300, 1'b0},
      '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h100, 1'b0, 32'h0,   1'b0}
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      e = sb_q.pop_front();
      got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL alias[%0d]: got=%h required=%h", i, got, e);
      end
    end
  endtask

  task automatic test_same_cycle();
    row_t rows [3];
    obs_t e;
    obs_t got;
    rows = '{
      '{1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0,   32'h100, 1'b0, 32'h0,   1'b1},
      '{1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200, 1'b1},
      '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h100, 1'b0, 32'h0,   1'b0}
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      e = sb_q.pop_front();
      got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL same_cycle[%0d]: got=%h required=%h", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows [2];
    obs_t e;
    obs_t got;
    rows = '{
      '{1'b1, 32'h100, 32'h280, 1'b1, 1'b0, 32'h0, 32'h100, 1'b0, 32'h0,   1'b1},
      '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0, 32'h100, 1'b1, 32'h280, 1'b0}
    };
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      e = sb_q.pop_front();
      got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL async_pre[%0d]: got=%h required=%h", i, got, e);
      end
    end
    // Assert reset between edges; effects must be visible immediately
    #1;
    rst = 1'b0;
    exp_bc = '0;
    exp_mc = '0;
    sb_q.push_back({1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    #1;
    e = sb_q.pop_front();
    got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
    checks++;
    if (got !== e) begin
      failures++; $display("FAIL async_during: got=%h required=%h", got, e);
    end
    // Present an update while still in reset; mispredict stays combinational
    updateEn = 1'b1; updatePC = 32'h100; updateTarget = 32'h200;
    actualTaken = 1'b1; exPredictTaken = 1'b0; exPredictTarget = '0;
    sb_q.push_back({1'b0, 32'h0, 1'b1, 32'h0, 32'h0});
    #1;
    e = sb_q.pop_front();
    got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
    checks++;
    if (got !== e) begin
      failures++; $display("FAIL async_rst_mp: got=%h required=%h", got, e);
    end
    #1;
    rst = 1'b1;
    // First edge after release must apply that update
    @(posedge clk);
    #1;
    updateEn = 1'b0;
    exp_bc = 32'd1;
    exp_mc = 32'd1;
    sb_q.push_back({1'b1, 32'h200, 1'b0, exp_bc, exp_mc});
    #1;
    e = sb_q.pop_front();
    got = {predictTaken, predictTarget, mispredict, branchCount, mispredictCount};
    checks++;
    if (got !== e) begin
      failures++; $display("FAIL async_first_update: got=%h required=%h", got, e);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_no_alloc();
    test_alias();
    test_same_cycle();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
